// File: rtl/y86_pkg.sv
// ---------------------------------------------------------------------------
// y86_pkg
// Shared Y86 definitions used by the execute-stage ALU.
//   ALU_*      : alufun operation codes (2 bits, all four codes are legal)
//   CC_*       : bit positions of the condition flags inside a 3-bit flag word
//   full_add() : one-bit full-adder slice, {carry_out, sum}
// ---------------------------------------------------------------------------
package y86_pkg;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_AND = 2'd2;
  localparam logic [1:0] ALU_XOR = 2'd3;

  localparam int CC_ZF = 0;
  localparam int CC_SF = 1;
  localparam int CC_OF = 2;

  // One full-adder slice; returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
    return {(a & b) | (c & (a ^ b)), a ^ b ^ c};
  endfunction

endpackage

// File: rtl/alu_adder64.sv
// ---------------------------------------------------------------------------
// alu_adder64
// Ripple-carry adder built from full-adder slices, shared by ADD and SUB.
//   i_a, i_b   : operands (caller inverts i_b for subtraction)
//   i_cin      : carry into bit 0 (1 for subtraction)
//   o_sum      : i_a + i_b + i_cin, modulo 2^WIDTH
//   o_overflow : two's-complement overflow of the addition
// ---------------------------------------------------------------------------
module alu_adder64
  import y86_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_overflow
);

  // NOTE: every variable driven here gets a default before the loop so no
  // path through the block leaves it unassigned, which would infer a latch.
  always_comb begin
    logic c;
    logic c_msb;
    c      = i_cin;
    c_msb  = 1'b0;
    o_sum  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i == WIDTH - 1) c_msb = c;
      {c, o_sum[i]} = full_add(i_a[i], i_b[i], c);
    end
    // Signed overflow: carry into the sign bit differs from carry out of it.
    // Because SUB feeds ~b with cin=1, this covers both operations.
    o_overflow = c_msb ^ c;
  end

endmodule

// File: rtl/alu64.sv
// ---------------------------------------------------------------------------
// alu64
// Y86 execute-stage ALU: ADD/SUB/AND/XOR with a same-cycle result and flags,
// plus one-cycle-delayed registered copies for debug/trace.
//   clk, rst_n : clock; synchronous active-low reset (registered outputs only)
//   alu_a      : operand A (valB: rB or %rsp)
//   alu_b      : operand B (valA, valC or constant 8)
//   alufun     : 0 ADD, 1 SUB (a - b), 2 AND, 3 XOR
//   result     : combinational result
//   overflow   : combinational signed overflow (0 for logical ops)
//   zero, sign : combinational result == 0, result MSB
//   result_q   : registered result
//   flags_q    : registered {OF, SF, ZF}
// ---------------------------------------------------------------------------
module alu64
  import y86_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  input  logic [1:0]       alufun,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             zero,
  output logic             sign,
  output logic [WIDTH-1:0] result_q,
  output logic [2:0]       flags_q
);

  logic             w_sub;
  logic [WIDTH-1:0] w_b_op;
  logic [WIDTH-1:0] w_sum;
  logic             w_add_ovf;

  logic [WIDTH-1:0] r_result;
  logic [2:0]       r_flags;

  // Subtraction reuses the adder as a + ~b + 1.
  assign w_sub  = (alufun == ALU_SUB);
  assign w_b_op = w_sub ? ~alu_b : alu_b;

  alu_adder64 #(.WIDTH(WIDTH)) u_adder (
    .i_a        (alu_a),
    .i_b        (w_b_op),
    .i_cin      (w_sub),
    .o_sum      (w_sum),
    .o_overflow (w_add_ovf)
  );

  always_comb begin
    result   = w_sum;
    overflow = 1'b0;
    case (alufun)
      ALU_ADD, ALU_SUB: begin
        result   = w_sum;
        overflow = w_add_ovf;
      end
      ALU_AND: result = alu_a & alu_b;
      ALU_XOR: result = alu_a ^ alu_b;
      default: ;
    endcase
  end

  assign zero = (result == '0);
  assign sign = result[WIDTH-1];

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples values from before the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_result <= '0;
      r_flags  <= 3'b000;
    end else begin
      r_result       <= result;
      r_flags[CC_OF] <= overflow;
      r_flags[CC_SF] <= sign;
      r_flags[CC_ZF] <= zero;
    end
  end

  assign result_q = r_result;
  assign flags_q  = r_flags;

endmodule

// File: tb/tb_alu64.sv
module tb_alu64;
  import y86_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] alu_a, alu_b;
  logic [1:0]  alufun;
  logic [63:0] result, result_q;
  logic        overflow, zero, sign;
  logic [2:0]  flags_q;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu64 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alufun   (alufun),
    .result   (result),
    .overflow (overflow),
    .zero     (zero),
    .sign     (sign),
    .result_q (result_q),
    .flags_q  (flags_q)
  );

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [1:0]  fun;
    logic [63:0] res;
    logic        ovf;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model from plain signed arithmetic: overflow means the exact
  // 65-bit signed result does not fit in 64 bits.
  function automatic logic [64:0] model(input logic [63:0] a, input logic [63:0] b,
                                        input logic [1:0] fun);
    logic signed [64:0] s;
    logic signed [64:0] sa, sb;
    sa = $signed({a[63], a});
    sb = $signed({b[63], b});
    case (fun)
      2'd0: begin s = sa + sb; return {s[64] != s[63], s[63:0]}; end
      2'd1: begin s = sa - sb; return {s[64] != s[63], s[63:0]}; end
      2'd2: return {1'b0, a & b};
      default: return {1'b0, a ^ b};
    endcase
  endfunction

  // Drive one operation, check the combinational outputs, then the registered
  // copies after the next rising edge.
  task automatic apply(input string tag, input logic [63:0] a, input logic [63:0] b,
                       input logic [1:0] fun, input logic [63:0] exp_res, input logic exp_ovf);
    logic exp_z, exp_s;
    alu_a  = a;
    alu_b  = b;
    alufun = fun;
    exp_z  = (exp_res == 64'd0);
    exp_s  = exp_res[63];
    #1;
    check({tag, " result"},   result,   exp_res);
    check({tag, " overflow"}, {63'd0, overflow}, {63'd0, exp_ovf});
    check({tag, " zero"},     {63'd0, zero},     {63'd0, exp_z});
    check({tag, " sign"},     {63'd0, sign},     {63'd0, exp_s});
    @(posedge clk); #1;
    check({tag, " result_q"}, result_q, exp_res);
    check({tag, " flags_q"},  {61'd0, flags_q}, {61'd0, exp_ovf, exp_s, exp_z});
  endtask

  initial begin
    logic [64:0] m;
    logic [1:0]  f;
    logic [63:0] ra, rb;

    vecs[0]  = '{64'd5, 64'd7, ALU_ADD, 64'd12, 1'b0};
    vecs[1]  = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, ALU_ADD, 64'h8000_0000_0000_0000, 1'b1};
    vecs[2]  = '{64'h100, 64'd8, ALU_SUB, 64'hF8, 1'b0};
    vecs[3]  = '{64'd3, 64'd3, ALU_SUB, 64'd0, 1'b0};
    vecs[4]  = '{64'h8000_0000_0000_0000, 64'd1, ALU_SUB, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1};
    vecs[5]  = '{64'hF0F0, 64'h0FF0, ALU_AND, 64'h00F0, 1'b0};
    vecs[6]  = '{64'hF0F0, 64'h0FF0, ALU_XOR, 64'hFF00, 1'b0};
    vecs[7]  = '{64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, ALU_XOR, 64'd0, 1'b0};
    vecs[8]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, ALU_ADD, 64'd0, 1'b0};
    vecs[9]  = '{64'd0, 64'd1, ALU_SUB, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[10] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, ALU_ADD, 64'd0, 1'b1};
    vecs[11] = '{64'd0, 64'h8000_0000_0000_0000, ALU_SUB, 64'h8000_0000_0000_0000, 1'b1};

    // Reset state.
    rst_n  = 1'b0;
    alu_a  = 64'd0;
    alu_b  = 64'd0;
    alufun = ALU_ADD;
    repeat (2) @(posedge clk);
    #1;
    check("reset result_q", result_q, 64'd0);
    check("reset flags_q",  {61'd0, flags_q}, 64'd0);

    // Reset held across an edge with live inputs: only registers are cleared.
    alu_a  = 64'd1;
    alu_b  = 64'd1;
    alufun = ALU_ADD;
    @(posedge clk); #1;
    check("rst hold result",   result,   64'd2);
    check("rst hold result_q", result_q, 64'd0);
    check("rst hold flags_q",  {61'd0, flags_q}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst release result_q", result_q, 64'd2);
    check("rst release flags_q",  {61'd0, flags_q}, 64'd0);

    // Directed table.
    for (int i = 0; i < 12; i++)
      apply($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].fun, vecs[i].res, vecs[i].ovf);

    // Mid-operation reset: registers clear, combinational path keeps tracking.
    alu_a  = 64'h7FFF_FFFF_FFFF_FFFF;
    alu_b  = 64'd1;
    alufun = ALU_ADD;
    rst_n  = 1'b0;
    @(posedge clk); #1;
    check("mid rst result_q",  result_q, 64'd0);
    check("mid rst flags_q",   {61'd0, flags_q}, 64'd0);
    check("mid rst overflow",  {63'd0, overflow}, 64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post rst flags_q",  {61'd0, flags_q}, 64'b110);

    // Randomized against the reference model, biased towards sign-boundary values.
    for (int i = 0; i < 300; i++) begin
      f  = 2'($urandom_range(0, 3));
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0: ra = 64'h7FFF_FFFF_FFFF_FFFF;
        1: rb = 64'h8000_0000_0000_0000;
        2: rb = ra;
        3: rb = 64'd8;
        default: ;
      endcase
      m = model(ra, rb, f);
      apply($sformatf("rand%0d", i), ra, rb, f, m[63:0], m[64]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
